// File: rtl/sap1_ram_loader_pkg.sv
// rtl/sap1_ram_loader_pkg.sv - shared widths and loader state encodings for the SAP-1 RAM loader
package sap1_ram_loader_pkg;

    localparam int SAP1_AW = 4;
    localparam int SAP1_DW = 8;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LOAD   = 3'd1,
        LDR_WRITE  = 3'd2,
        LDR_VERIFY = 3'd3,
        LDR_DONE   = 3'd4
    } ldr_state_t;

endpackage

// File: rtl/sap1_ram_loader.sv
// rtl/sap1_ram_loader.sv - streams program bytes into the SAP-1 RAM, optionally verifies an XOR checksum
module sap1_ram_loader
    import sap1_ram_loader_pkg::*;
#(
    parameter int AW        = SAP1_AW,
    parameter int DW        = SAP1_DW,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [DW-1:0] ram_q,
    output logic          ram_prog,
    output logic          ram_write,
    output logic          ram_ce,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] A_LAST = '1;

    ldr_state_t    state, state_n;
    logic          in_ready_n, prog_n, write_n, ce_n, busy_n, done_n, err_n;
    logic [AW-1:0] a_n;
    logic [DW-1:0] d_n, sum, sum_n, chk, chk_n;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= LDR_IDLE;
            in_ready  <= 1'b0;
            ram_prog  <= 1'b0;
            ram_write <= 1'b0;
            ram_ce    <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
            chk       <= '0;
        end else begin
            state     <= state_n;
            in_ready  <= in_ready_n;
            ram_prog  <= prog_n;
            ram_write <= write_n;
            ram_ce    <= ce_n;
            ram_a     <= a_n;
            ram_d     <= d_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            sum       <= sum_n;
            chk       <= chk_n;
        end
    end

    // Every output is a register; this block only computes the next value of each one.
    always_comb begin
        state_n    = state;
        in_ready_n = in_ready;
        prog_n     = ram_prog;
        write_n    = ram_write;
        ce_n       = ram_ce;
        a_n        = ram_a;
        d_n        = ram_d;
        busy_n     = busy;
        done_n     = done;
        err_n      = err;
        sum_n      = sum;
        chk_n      = chk;
        unique case (state)
            LDR_IDLE: begin
                if (start) begin
                    state_n    = LDR_LOAD;
                    in_ready_n = 1'b1;
                    prog_n     = 1'b1;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    err_n      = 1'b0;
                    a_n        = '0;
                    sum_n      = '0;
                end
            end
            LDR_LOAD: begin
                if (in_valid && in_ready) begin
                    state_n    = LDR_WRITE;
                    in_ready_n = 1'b0;
                    d_n        = in_data;
                    sum_n      = sum ^ in_data;
                    write_n    = 1'b1;
                end
            end
            LDR_WRITE: begin
                write_n = 1'b0;
                if (ram_a == A_LAST) begin
                    a_n = '0;
                    if (VERIFY_EN) begin
                        // Drop program mode before enabling the output so prog and ce never overlap.
                        state_n = LDR_VERIFY;
                        prog_n  = 1'b0;
                        ce_n    = 1'b1;
                        chk_n   = '0;
                    end else begin
                        state_n = LDR_DONE;
                    end
                end else begin
                    a_n        = ram_a + AW'(1);
                    in_ready_n = 1'b1;
                    state_n    = LDR_LOAD;
                end
            end
            LDR_VERIFY: begin
                chk_n = chk ^ ram_q;
                if (ram_a == A_LAST) begin
                    a_n     = '0;
                    err_n   = ((chk ^ ram_q) != sum);
                    state_n = LDR_DONE;
                end else begin
                    a_n = ram_a + AW'(1);
                end
            end
            LDR_DONE: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                prog_n  = 1'b0;
                ce_n    = 1'b0;
                a_n     = '0;
                state_n = LDR_IDLE;
            end
            default: begin
                state_n = LDR_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sap1_ram_loader.sv
// tb/tb_sap1_ram_loader.sv - scoreboard bench for sap1_ram_loader with and without readback verify
module tb_sap1_ram_loader;

    logic       clk, clr_n, start_a, start_b, in_valid, corrupt_en;
    logic [7:0] in_data;

    logic       d0_ready, d0_prog, d0_write, d0_ce, d0_busy, d0_done, d0_err;
    logic [3:0] d0_a;
    logic [7:0] d0_d, q0;
    logic       d1_ready, d1_prog, d1_write, d1_ce, d1_busy, d1_done, d1_err;
    logic [3:0] d1_a;
    logic [7:0] d1_d, q1;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];

    logic [11:0] exp_wr0[$], exp_wr1[$];
    logic [31:0] exp_dn0[$], exp_dn1[$];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, t_start = 0;
    int viol0 = 0, ce1_cnt = 0, rdy_diff = 0;
    logic w0_q, w1_q, dn0_q, dn1_q;
    logic [31:0] e_pop;

    sap1_ram_loader #(.AW(4), .DW(8), .VERIFY_EN(1'b1)) dut (
        .clk(clk), .clr_n(clr_n), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d0_ready), .ram_q(q0), .ram_prog(d0_prog), .ram_write(d0_write), .ram_ce(d0_ce),
        .ram_a(d0_a), .ram_d(d0_d), .busy(d0_busy), .done(d0_done), .err(d0_err)
    );

    sap1_ram_loader #(.AW(4), .DW(8), .VERIFY_EN(1'b0)) dut_nv (
        .clk(clk), .clr_n(clr_n), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d1_ready), .ram_q(q1), .ram_prog(d1_prog), .ram_write(d1_write), .ram_ce(d1_ce),
        .ram_a(d1_a), .ram_d(d1_d), .busy(d1_busy), .done(d1_done), .err(d1_err)
    );

    // RAM16x8 models; address 7 of the verified RAM can have bit 0 of its read data flipped.
    always @(posedge clk) begin
        if (d0_prog && d0_write) mem0[d0_a] <= d0_d;
        if (d1_prog && d1_write) mem1[d1_a] <= d1_d;
    end
    assign q0 = d0_ce ? (mem0[d0_a] ^ {7'b0, (corrupt_en && d0_a == 4'd7)}) : 8'h00;
    assign q1 = d1_ce ? mem1[d1_a] : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    always @(negedge clk) begin
        if (!clr_n) begin
            w0_q <= 1'b0; w1_q <= 1'b0; dn0_q <= 1'b0; dn1_q <= 1'b0;
        end else begin
            if (d0_write) begin
                chk("dut write strobe 1 cycle", {31'd0, w0_q}, 32'd0);
                if (exp_wr0.size() == 0) fail("dut unexpected write", {d0_a, d0_d});
                else chk("dut write a/d", {d0_a, d0_d}, exp_wr0.pop_front());
            end
            if (d1_write) begin
                chk("dut_nv write strobe 1 cycle", {31'd0, w1_q}, 32'd0);
                if (exp_wr1.size() == 0) fail("dut_nv unexpected write", {d1_a, d1_d});
                else chk("dut_nv write a/d", {d1_a, d1_d}, exp_wr1.pop_front());
            end
            if (d0_done && !dn0_q) begin
                if (exp_dn0.size() == 0) fail("dut unexpected done", 32'd1);
                else begin
                    e_pop = exp_dn0.pop_front();
                    chk("dut err", {31'd0, d0_err}, {31'd0, e_pop[31]});
                    chk("dut done latency", cyc - t_start, {1'b0, e_pop[30:0]});
                end
            end
            if (d1_done && !dn1_q) begin
                if (exp_dn1.size() == 0) fail("dut_nv unexpected done", 32'd1);
                else begin
                    e_pop = exp_dn1.pop_front();
                    chk("dut_nv err", {31'd0, d1_err}, {31'd0, e_pop[31]});
                    chk("dut_nv done latency", cyc - t_start, {1'b0, e_pop[30:0]});
                end
            end
            if (d0_ce && (d0_prog || d0_write)) viol0 <= viol0 + 1;
            if (d1_ce) ce1_cnt <= ce1_cnt + 1;
            if (d0_ready != d1_ready) rdy_diff <= rdy_diff + 1;
            w0_q <= d0_write; w1_q <= d1_write; dn0_q <= d0_done; dn1_q <= d1_done;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!d0_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!d0_ready) fail("in_ready timeout", {24'd0, b});
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            chk("in_ready held during stall", {31'd0, d0_ready}, 32'd1);
        end
    endtask

    task automatic run_load(input logic [7:0] base, input int gap, input bit corrupt, input bit pulses,
                            input int lat0, input int lat1, input bit e0, input bit e1);
        int n;
        logic [7:0] b;
        corrupt_en = corrupt;
        if (pulses) begin
            in_data  = 8'hEE;
            in_valid = 1'b1;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            b = base + 8'(i);
            exp_wr0.push_back({4'(i), b});
            exp_wr1.push_back({4'(i), b});
        end
        exp_dn0.push_back({e0, 31'(lat0)});
        exp_dn1.push_back({e1, 31'(lat1)});
        start_a = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        t_start = cyc;
        for (int i = 0; i < 16; i++) begin
            b = base + 8'(i);
            if (pulses && i == 4) begin start_a = 1'b1; start_b = 1'b1; end
            send_byte(b, (i == 15) ? 0 : gap);
            start_a = 1'b0; start_b = 1'b0;
        end
        if (pulses) begin
            in_data = 8'hEE;
            repeat (3) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while ((exp_dn0.size() != 0 || exp_dn1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_dn0.size() != 0 || exp_dn1.size() != 0) fail("done timeout", {24'd0, base});
        exp_dn0.delete(); exp_dn1.delete();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pending writes", exp_wr0.size() + exp_wr1.size(), 32'd0);
        chk("dut idle flags busy/prog/ce/done", {d0_busy, d0_prog, d0_ce, d0_done}, 32'b0001);
        chk("dut_nv idle flags busy/prog/ce/done", {d1_busy, d1_prog, d1_ce, d1_done}, 32'b0001);
        for (int i = 0; i < 16; i++) begin
            b = base + 8'(i);
            chk("dut mem", {24'd0, mem0[i]}, {24'd0, b});
            chk("dut_nv mem", {24'd0, mem1[i]}, {24'd0, b});
        end
        chk("dut ce with prog/write", viol0, 32'd0);
        chk("dut_nv ce ever 1", ce1_cnt, 32'd0);
        chk("in_ready agreement", rdy_diff, 32'd0);
        exp_wr0.delete(); exp_wr1.delete();
        corrupt_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; corrupt_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("dut reset outputs", {d0_ready, d0_prog, d0_write, d0_ce, d0_a, d0_d, d0_busy, d0_done, d0_err}, 32'd0);
        chk("dut_nv reset outputs", {d1_ready, d1_prog, d1_write, d1_ce, d1_a, d1_d, d1_busy, d1_done, d1_err}, 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            exp_wr0.push_back({4'(i), 8'h30 + 8'(i)});
            exp_wr1.push_back({4'(i), 8'h30 + 8'(i)});
        end
        start_a = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ram_a before abort", {28'd0, d0_a}, 32'd5);
        chk("busy before abort", {31'd0, d0_busy}, 32'd1);
        #2 clr_n = 1'b0;
        #1;
        chk("dut async reset outputs", {d0_ready, d0_prog, d0_write, d0_ce, d0_a, d0_d, d0_busy, d0_done, d0_err}, 32'd0);
        chk("dut_nv async reset outputs", {d1_ready, d1_prog, d1_write, d1_ce, d1_a, d1_d, d1_busy, d1_done, d1_err}, 32'd0);
        chk("writes before abort", exp_wr0.size() + exp_wr1.size(), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        run_load(8'h10, 0, 1'b0, 1'b0, 49, 33, 1'b0, 1'b0);
        run_load(8'hA0, 3, 1'b0, 1'b0, 79, 63, 1'b0, 1'b0);
        run_load(8'h55, 0, 1'b1, 1'b0, 49, 33, 1'b1, 1'b0);
        run_load(8'hC3, 0, 1'b0, 1'b1, 49, 33, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
